fetch_unit: RTL and testbench

Instruction fetch front end that owns the program counter and consumes the branch unit's resolution outputs (taken flag, target PC) to redirect fetch. It issues word requests to instruction memory over a request/grant, in-order response interface and buffers returned words in a 2-entry queue toward decode. It discards responses made stale by a redirect, tracked with an outstanding/drop counter pair.

---
 rtl/fetch_unit_if.sv | 19 +
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant bus with in-order responses.
// The fetch unit is the master; the memory (or its model) is the slave.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues word fetches, buffers up to two
// returned instructions for decode and drops responses made stale by a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_b_valid,
  input  logic          i_b_taken,
  input  logic [31:0]   i_b_pc,
  fetch_unit_if.master  imem,
  output logic          o_inst_valid,
  output logic [31:0]   o_inst,
  output logic [31:0]   o_inst_pc,
  input  logic          i_inst_ready,
  output logic          o_misaligned
);

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic [1:0]  r_out;
  logic [1:0]  r_drop;
  logic        r_mis;
  logic [31:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_inst [2];
  logic [31:0] r_pq        [2];

  logic        w_redirect;
  logic        w_pop;
  logic        w_push;
  logic        w_req;
  logic        w_hs;
  logic        w_rsp_drop;
  logic [2:0]  w_credits;
  logic [1:0]  w_drop_redir;
  logic [1:0]  w_drop_nxt;
  logic        w_fifo_wi;
  logic        w_pq_wi;

  // Redirects are ignored in RESET; nothing is in flight there yet.
  assign w_redirect   = i_b_valid & i_b_taken & (r_state != S_RESET);
  assign w_pop        = (r_count != 2'd0) & i_inst_ready & ~w_redirect;
  assign w_rsp_drop   = imem.imem_rvalid & (r_drop != 2'd0);
  assign w_push       = imem.imem_rvalid & (r_drop == 2'd0) & ~w_redirect;

  // A head popped this cycle frees its slot, which sustains one fetch per cycle.
  assign w_credits    = {1'b0, r_out} + {1'b0, r_drop} + {1'b0, r_count} - {2'b00, w_pop};
  assign w_req        = (r_state != S_RESET) & (w_credits < 3'd2) & ~w_redirect;
  assign w_hs         = w_req & imem.imem_gnt;

  assign w_drop_redir = r_drop + r_out - {1'b0, imem.imem_rvalid};
  assign w_drop_nxt   = w_redirect ? w_drop_redir : (r_drop - {1'b0, w_rsp_drop});

  // Write slots are (count - pop) and (out - live response); both fit in one bit.
  assign w_fifo_wi    = r_count[0] ^ w_pop;
  assign w_pq_wi      = r_out[0] ^ w_push;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_RESET;
      r_pc           <= RESET_PC;
      r_count        <= 2'd0;
      r_out          <= 2'd0;
      r_drop         <= 2'd0;
      r_mis          <= 1'b0;
      r_fifo_pc[0]   <= 32'd0;
      r_fifo_pc[1]   <= 32'd0;
      r_fifo_inst[0] <= 32'd0;
      r_fifo_inst[1] <= 32'd0;
    end else begin
      r_mis <= w_redirect & (|i_b_pc[1:0]);
      if (r_state == S_RESET) r_state <= S_FETCH;
      else                    r_state <= (w_drop_nxt != 2'd0) ? S_DRAIN : S_FETCH;
      r_drop <= w_drop_nxt;
      if (w_redirect) begin
        r_pc    <= {i_b_pc[31:2], 2'b00};
        r_count <= 2'd0;
        r_out   <= 2'd0;
      end else begin
        if (w_hs) r_pc <= r_pc + 32'd4;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        r_out   <= r_out + {1'b0, w_hs} - {1'b0, w_push};
        if (w_pop) begin
          r_fifo_pc[0]   <= r_fifo_pc[1];
          r_fifo_inst[0] <= r_fifo_inst[1];
        end
        if (w_push) begin
          r_fifo_pc[w_fifo_wi]   <= r_pq[0];
          r_fifo_inst[w_fifo_wi] <= imem.imem_rdata;
        end
      end
    end
  end

  // Addresses of live outstanding requests, oldest at index 0.
  always_ff @(posedge i_clk) begin
    if (w_push) r_pq[0] <= r_pq[1];
    if (w_hs)   r_pq[w_pq_wi] <= r_pc;
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign o_inst_valid   = (r_count != 2'd0);
  assign o_inst         = r_fifo_inst[0];
  assign o_inst_pc      = r_fifo_pc[0];
  assign o_misaligned   = r_mis;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against an in-order memory model
// and a program-order reference of fetch addresses and delivered instructions.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_valid, b_taken;
  logic [31:0] b_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        misaligned;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_b_valid(b_valid), .i_b_taken(b_taken), .i_b_pc(b_pc),
    .imem(imem),
    .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_inst_ready(inst_ready), .o_misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // memory model: in-order queue of accepted addresses with due cycle
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          last_due = 0;

  // program-order reference
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_inst  = RESET_PC;
  logic        exp_mis   = 1'b0;
  int          stall     = 0;

  // values sampled during the latest step
  logic        s_req, s_hs, s_valid, s_mis;
  logic [31:0] s_addr, s_inst, s_inst_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F69;
  endfunction

  function automatic bit mem_due();
    return (mq_addr.size() > 0) && (mq_due[0] <= cyc);
  endfunction

  // One clock cycle: drive at the negedge, sample 1 time unit later, then
  // let the rising edge happen and return at the following negedge.
  task automatic step(input logic rs, input logic bv, input logic bt,
                      input logic [31:0] bpc, input logic rdy, input logic g, input int lat);
    logic resp, redir, popped;
    rst = rs; b_valid = bv; b_taken = bt; b_pc = bpc;
    inst_ready = rdy; imem.imem_gnt = g;
    resp = mem_due();
    imem.imem_rvalid = resp;
    imem.imem_rdata  = resp ? mem_word(mq_addr[0]) : $urandom;
    #1;
    s_req = imem.imem_req; s_addr = imem.imem_addr; s_hs = imem.imem_req & g;
    s_valid = inst_valid; s_inst = inst; s_inst_pc = inst_pc; s_mis = misaligned;
    redir = bv & bt;
    popped = 1'b0;
    if (resp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (rs) begin
      mq_addr.delete(); mq_due.delete(); last_due = 0;
      exp_fetch = RESET_PC; exp_inst = RESET_PC; exp_mis = 1'b0; stall = 0;
    end else begin
      check("misaligned", {31'd0, s_mis}, {31'd0, exp_mis});
      if (redir) check("req_in_redirect", {31'd0, s_req}, 32'd0);
      if (s_hs) begin
        check("fetch_addr", s_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        mq_addr.push_back(s_addr);
        mq_due.push_back(last_due);
      end
      if (s_valid && rdy && !redir) begin
        check("inst_pc", s_inst_pc, exp_inst);
        check("inst_word", s_inst, mem_word(exp_inst));
        exp_inst = exp_inst + 32'd4;
        popped = 1'b1;
      end
      if (redir) begin
        exp_fetch = {bpc[31:2], 2'b00};
        exp_inst  = {bpc[31:2], 2'b00};
      end
      exp_mis = redir && (bpc[1:0] != 2'b00);
      if (rdy && !redir && !popped) stall++;
      else stall = 0;
      if (stall == 30) check("no_progress", stall, 32'd0);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy, input logic g, input int lat);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, rdy, g, lat);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    int found;
    int nhs;
    logic [31:0] wa [3];
    rst = 1'b1; b_valid = 1'b0; b_taken = 1'b0; b_pc = 32'd0; inst_ready = 1'b0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'd0;
    @(negedge clk);
    do_reset();
    check("reset_req",   {31'd0, imem.imem_req}, 32'd0);
    check("reset_addr",  imem.imem_addr, RESET_PC);
    check("reset_valid", {31'd0, inst_valid}, 32'd0);
    check("reset_inst",  inst, 32'd0);
    check("reset_pc",    inst_pc, 32'd0);
    check("reset_mis",   {31'd0, misaligned}, 32'd0);

    // streaming at one instruction per cycle
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("release_req", {31'd0, s_req}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
      check("stream_req", {31'd0, s_req}, 32'd1);
      check("stream_addr", s_addr, RESET_PC + 32'(4 * k));
      if (k >= 2) begin
        check("stream_valid", {31'd0, s_valid}, 32'd1);
        check("stream_pc", s_inst_pc, RESET_PC + 32'(4 * (k - 2)));
      end
    end

    // decode stalls: fifo fills, requests stop, then resume without loss
    idle(6, 1'b0, 1'b1, 1);
    check("full_req", {31'd0, s_req}, 32'd0);
    check("full_valid", {31'd0, s_valid}, 32'd1);
    idle(10, 1'b1, 1'b1, 1);

    // redirect with two outstanding requests, latency 3
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3);
    idle(2, 1'b1, 1'b1, 3);
    check("two_outstanding", mq_addr.size(), 32'd2);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 3);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3);
      if (s_valid) begin
        found = 1;
        check("redir_first_pc", s_inst_pc, 32'h0000_0100);
      end
    end
    if (found == 0) check("redir_timeout", found, 32'd1);

    // redirect coinciding with a response and a pop
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (mem_due() && inst_valid) begin
        found = 1;
        step(1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 2);
        check("flush_empty", {31'd0, inst_valid}, 32'd0);
      end else begin
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 2);
      end
    end
    if (found == 0) check("coincide_timeout", found, 32'd1);
    idle(8, 1'b1, 1'b1, 2);

    // misaligned target
    step(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("mis_pulse", {31'd0, s_mis}, 32'd1);
    found = s_hs ? 1 : 0;
    if (s_hs) check("mis_target", s_addr, 32'h0000_0200);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("mis_clear", {31'd0, s_mis}, 32'd0);
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (s_hs) begin
        found = 1;
        check("mis_target", s_addr, 32'h0000_0200);
      end else begin
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
      end
    end
    if (found == 0) check("mis_timeout", found, 32'd1);

    // address wrap
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
    nhs = 0;
    for (int i = 0; i < 30 && nhs < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
      if (s_hs) begin
        wa[nhs] = s_addr;
        nhs++;
      end
    end
    check("wrap_count", nhs, 32'd3);
    if (nhs == 3) begin
      check("wrap_a0", wa[0], 32'hFFFF_FFF8);
      check("wrap_a1", wa[1], 32'hFFFF_FFFC);
      check("wrap_a2", wa[2], 32'h0000_0000);
    end

    // reset in the middle of a stream
    idle(4, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("rst_gap_req", {31'd0, s_req}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    check("rst_restart_req", {31'd0, s_req}, 32'd1);
    check("rst_restart_addr", s_addr, RESET_PC);
    idle(4, 1'b1, 1'b1, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic bv, bt, rdy, g;
      logic [31:0] tgt;
      bv  = ($urandom_range(0, 99) < 6);
      bt  = bv && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      g   = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom & 32'h0000_0FFF;
        1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2:       tgt = $urandom;
        default: tgt = $urandom & 32'hFFFF_FFFC;
      endcase
      step(1'b0, bv, bt, tgt, rdy, g, $urandom_range(1, 4));
    end
    idle(20, 1'b1, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
